// File: rtl/serial_tx.sv
// Byte-wide to serial transmitter: 8 data bits, LSB first, 1 or 2 stop bits.
// Pulls bytes from a registered upstream buffer with a two-cycle DataNext pulse per byte.
module serial_tx #(
  parameter int BITTIME   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DataAvail,
  input  logic [7:0] DataVal,
  input  logic       txEnable,
  output logic       DataNext,
  output logic       txd,
  output logic       busy
);

  localparam int CW = (BITTIME > 1) ? $clog2(BITTIME) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BITTIME - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT         state, stateNext;
  logic [CW-1:0] baudCnt, baudNext;
  logic [2:0]    bitIdx, bitNext;
  logic          stopIdx, stopNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          txdNext, busyNext, consumeNext;
  logic          bitEnd;

  assign bitEnd = (baudCnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      stopIdx  <= 1'b0;
      shiftReg <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      DataNext <= 1'b0;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      stopIdx  <= stopNext;
      shiftReg <= shiftNext;
      txd      <= txdNext;
      busy     <= busyNext;
      DataNext <= consumeNext;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    stateNext   = state;
    baudNext    = baudCnt + CW'(1);
    bitNext     = bitIdx;
    stopNext    = stopIdx;
    shiftNext   = shiftReg;
    txdNext     = txd;
    busyNext    = busy;
    consumeNext = 1'b0;

    case (state)
      IDLE: begin
        baudNext = '0;
        txdNext  = 1'b1;
        busyNext = 1'b0;
        if (DataAvail && txEnable) begin
          stateNext   = START;
          shiftNext   = DataVal;
          txdNext     = 1'b0;
          busyNext    = 1'b1;
          consumeNext = 1'b1;
          bitNext     = '0;
          stopNext    = 1'b0;
        end
      end

      START: begin
        // Second DataNext cycle; the pulse ends once the baud counter has advanced.
        consumeNext = (baudCnt == '0);
        if (bitEnd) begin
          baudNext  = '0;
          stateNext = DATA;
          txdNext   = shiftReg[0];
        end
      end

      DATA: begin
        if (bitEnd) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txdNext   = 1'b1;
          end else begin
            shiftNext = {1'b0, shiftReg[7:1]};
            txdNext   = shiftReg[1];
            bitNext   = bitIdx + 3'd1;
          end
        end
      end

      STOP: begin
        if (bitEnd) begin
          baudNext = '0;
          if (stopIdx == STOP_LAST) begin
            stateNext = IDLE;
            busyNext  = 1'b0;
            txdNext   = 1'b1;
          end else begin
            stopNext = 1'b1;
          end
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at BITTIME=16/1 stop, one at BITTIME=4/2 stops,
// each fed by a small upstream queue that pops on every DataNext rising edge.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txEnable = 1'b1;
  logic       DataAvail = 1'b0;
  logic [7:0] DataVal = 8'h00;
  logic       DataNext, txd, busy;
  logic       DataAvail2 = 1'b0;
  logic [7:0] DataVal2 = 8'h00;
  logic       DataNext2, txd2, busy2;

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int dnRises = 0;
  int dnRises2 = 0;
  int lastDnHigh = 0;
  logic dnPrev = 1'b0;
  logic dnPrev2 = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  serial_tx #(.BITTIME(16), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .DataAvail(DataAvail), .DataVal(DataVal), .txEnable(txEnable),
    .DataNext(DataNext), .txd(txd), .busy(busy)
  );

  serial_tx #(.BITTIME(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .DataAvail(DataAvail2), .DataVal(DataVal2), .txEnable(txEnable),
    .DataNext(DataNext2), .txd(txd2), .busy(busy2)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // Upstream buffers: consume one byte per DataNext rising edge, refresh flag/data off the active edge.
  always @(negedge clk) begin
    if (DataNext && !dnPrev) begin
      dnRises++;
      if (q0.size() != 0) void'(q0.pop_front());
    end
    if (DataNext2 && !dnPrev2) begin
      dnRises2++;
      if (q1.size() != 0) void'(q1.pop_front());
    end
    dnPrev  = DataNext;
    dnPrev2 = DataNext2;
    DataAvail  = (q0.size() != 0);
    DataVal    = (q0.size() != 0) ? q0[0] : 8'h00;
    DataAvail2 = (q1.size() != 0);
    DataVal2   = (q1.size() != 0) ? q1[0] : 8'h00;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      q0.push_back(b);
      DataAvail = 1'b1;
      DataVal   = q0[0];
    end else begin
      q1.push_back(b);
      DataAvail2 = 1'b1;
      DataVal2   = q1[0];
    end
  endtask

  function automatic logic getTxd(input int sel);
    return (sel != 0) ? txd2 : txd;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel != 0) ? busy2 : busy;
  endfunction

  function automatic logic getDn(input int sel);
    return (sel != 0) ? DataNext2 : DataNext;
  endfunction

  task automatic waitStart(input int sel, input int maxCycles, output int latency);
    latency = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge clk);
      if (getBusy(sel)) begin
        latency = i;
        break;
      end
    end
  endtask

  // Starts on the first start-bit cycle; counts high cycles of txd per bit period.
  task automatic checkFrame(input string tag, input int sel, input logic [7:0] b,
                            input int nBits, input int dropBit);
    int bt;
    int ones;
    logic lvl;
    bt = (sel != 0) ? 4 : 16;
    lastDnHigh = 0;
    for (int k = 0; k < nBits; k++) begin
      if (k == 0) lvl = 1'b0;
      else if (k <= 8) lvl = b[k-1];
      else lvl = 1'b1;
      ones = 0;
      for (int c = 0; c < bt; c++) begin
        if (!(k == 0 && c == 0)) @(negedge clk);
        if (k == dropBit && c == 0) txEnable = 1'b0;
        if (getTxd(sel)) ones++;
        if (getDn(sel)) lastDnHigh++;
      end
      checkOutput($sformatf("%s bit%0d", tag, k), ones, lvl ? bt : 0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, s0, s1, s2, rBase, cntTxd, cntDn, cntBusy;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset txd", int'(txd), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset DataNext", int'(DataNext), 0);
    checkOutput("reset txd2", int'(txd2), 1);
    checkOutput("reset busy2", int'(busy2), 0);
    rst = 1'b0;

    cntTxd = 0; cntDn = 0; cntBusy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd) cntTxd++;
      if (DataNext) cntDn++;
      if (busy) cntBusy++;
    end
    checkOutput("empty txd high cycles", cntTxd, 1000);
    checkOutput("empty DataNext cycles", cntDn, 0);
    checkOutput("empty busy cycles", cntBusy, 0);

    @(posedge clk);
    #1;
    applyStimulus(0, 8'hA5);
    waitStart(0, 5, lat);
    checkOutput("a5 start latency", lat, 2);
    checkFrame("a5", 0, 8'hA5, 10, -1);
    checkOutput("a5 DataNext cycles", lastDnHigh, 2);
    @(negedge clk);
    checkOutput("a5 idle busy", int'(busy), 0);
    checkOutput("a5 idle txd", int'(txd), 1);
    checkOutput("a5 DataNext edges", dnRises, 1);

    rBase = dnRises;
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    applyStimulus(0, 8'h7F);
    waitStart(0, 5, lat);
    s0 = cycle;
    checkFrame("b2b 00", 0, 8'h00, 10, -1);
    waitStart(0, 5, lat);
    s1 = cycle;
    checkOutput("b2b period 1", s1 - s0, 161);
    checkFrame("b2b FF", 0, 8'hFF, 10, -1);
    waitStart(0, 5, lat);
    s2 = cycle;
    checkOutput("b2b period 2", s2 - s1, 161);
    checkFrame("b2b 7F", 0, 8'h7F, 10, -1);
    repeat (20) @(negedge clk);
    checkOutput("b2b DataNext edges", dnRises - rBase, 3);

    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'h99);
    waitStart(0, 5, lat);
    checkFrame("txen 3C", 0, 8'h3C, 10, 4);
    rBase = dnRises;
    cntBusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) cntBusy++;
    end
    checkOutput("txen off busy cycles", cntBusy, 0);
    checkOutput("txen off DataNext edges", dnRises - rBase, 0);
    txEnable = 1'b1;
    waitStart(0, 5, lat);
    checkOutput("txen resume latency", lat, 1);
    checkFrame("txen 99", 0, 8'h99, 10, -1);

    applyStimulus(0, 8'hC3);
    applyStimulus(0, 8'h5A);
    waitStart(0, 5, lat);
    checkFrame("rst C3", 0, 8'hC3, 6, -1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst mid txd", int'(txd), 1);
    checkOutput("rst mid busy", int'(busy), 0);
    checkOutput("rst mid DataNext", int'(DataNext), 0);
    rst = 1'b0;
    waitStart(0, 5, lat);
    checkOutput("rst restart latency", lat, 1);
    checkFrame("rst 5A", 0, 8'h5A, 10, -1);

    @(negedge clk);
    applyStimulus(0, 8'hE7);
    waitStart(0, 5, lat);
    checkOutput("dn at start", int'(DataNext), 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("dn after rst", int'(DataNext), 0);
    checkOutput("txd after rst", int'(txd), 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("no retransmit busy", int'(busy), 0);

    applyStimulus(1, 8'h55);
    applyStimulus(1, 8'h55);
    waitStart(1, 5, lat);
    s0 = cycle;
    checkFrame("s2 first", 1, 8'h55, 11, -1);
    checkOutput("s2 DataNext cycles", lastDnHigh, 2);
    waitStart(1, 5, lat);
    s1 = cycle;
    checkOutput("s2 period", s1 - s0, 45);
    checkFrame("s2 second", 1, 8'h55, 11, -1);
    repeat (5) @(negedge clk);
    checkOutput("s2 DataNext edges", dnRises2, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-002 Parameter BITTIME, default 16: clk cycles per serial bit; legal range 4..65535.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 DataAvail  input  1  upstream byte buffer non-empty (registered upstream).
REQ-007 DataVal  input  8  byte at upstream read pointer; valid while DataAvail=1.
REQ-008 txEnable  input  1  permits new frame starts; low = finish current frame, then hold idle.
REQ-009 DataNext  output  1  byte-consume request; upstream acts on its rising edge only.
REQ-010 txd  output  1  serial line, idle high, 8N1 or 8N2 framing, LSB first.
REQ-011 busy  output  1  high from frame start until the final stop-bit cycle inclusive.

Function
REQ-012 The FSM SHALL use states IDLE, START, DATA, STOP; all outputs registered.
REQ-013 IDLE: if DataAvail=1 and txEnable=1 at edge T, then at T+1 shift register<=DataVal, txd=0, busy=1, DataNext=1, state=START, bit counter=0.
REQ-014 DataNext SHALL be high for exactly 2 cycles (T+1, T+2) and low from T+3, giving one rising edge per byte.
REQ-015 DataAvail and DataVal SHALL be ignored outside IDLE, covering the upstream 2-cycle pointer/flag update lag.
REQ-016 Baud counter SHALL count 0..BITTIME-1; each bit period is exactly BITTIME cycles.
REQ-017 START: txd=0 for BITTIME cycles, then DATA with txd=shift[0].
REQ-018 DATA: shift right at each bit-period end; 8 bits, LSB first; after bit 7, STOP.
REQ-019 STOP: txd=1 for STOP_BITS*BITTIME cycles; at the end, state=IDLE, busy=0.
REQ-020 IDLE SHALL be entered for at least one cycle between frames; minimum frame period = (9+STOP_BITS)*BITTIME+1 cycles.
REQ-021 In IDLE: txd=1, DataNext=0, busy=0.
REQ-022 txEnable falling mid-frame SHALL NOT truncate the frame; it is evaluated only in IDLE.
REQ-023 With DataAvail=0 in IDLE, the block SHALL remain idle indefinitely with no DataNext edge.
REQ-024 Counter widths SHALL accommodate BITTIME-1 and bit index 0..7 without wrap error at the maximum parameter values.

Reset
REQ-025 While rst=1 at an edge, the next cycle SHALL show state=IDLE, txd=1, DataNext=0, busy=0, and cleared counters and shift register.
REQ-026 Reset mid-frame SHALL abandon the frame: txd=1 on the cycle after the edge; the consumed byte is not retransmitted.
REQ-027 DataNext, if high at reset, SHALL drop to 0 on the next cycle.

Verification
REQ-028 Single byte: BITTIME=16, DataVal=8'hA5, DataAvail pulse -> txd sequence 0,1,0,1,0,0,1,0,1,1, each level 16 cycles; DataNext high for exactly 2 cycles.
REQ-029 Back-to-back: 3 bytes 8'h00, 8'hFF, 8'h7F queued -> three frames, each start 161 cycles apart, exactly 3 DataNext rising edges.
REQ-030 STOP_BITS=2, BITTIME=4, DataVal=8'h55 -> stop high for 8 cycles; next start no earlier than 45 cycles after the previous start.
REQ-031 txEnable dropped during bit 3 -> frame completes unchanged; no new DataNext edge while txEnable=0 even with DataAvail=1; resumes within 1 cycle of txEnable=1.
REQ-032 rst asserted during DATA bit 5 -> txd=1, busy=0, DataNext=0 next cycle; after release with DataAvail=1, a fresh frame starts 1 cycle later.
REQ-033 Empty upstream: DataAvail=0 for 1000 cycles -> txd constantly 1, DataNext constantly 0, busy constantly 0.
